vga_write_queue: RTL and testbench

- Elastic buffer between the CPU's memory-mapped VGA store path (stores at or above 0x00070000) and the ascii_master_controller text-RAM write port.
- Accepts one store per push and holds it in a FIFO, so CPU stores are never lost while the text RAM is busy.
- Drains stores as single-character writes over a valid/ready handshake.
- Reports full so the CPU FSM can hold in WAIT_UPDATE.

---
 rtl/vga_queue_pkg.sv | 19 +
 rtl/vga_write_queue_sync_fifo.sv | 69 ++++++
 rtl/vga_write_queue.sv | 165 ++++++++++++++++
 tb/tb_vga_write_queue.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_queue_pkg.sv
// Shared definitions for the VGA write queue: output-stage FSM states,
// the VGA region base address and the NUL character.
// Optional feature macro used by the design: VGA_WORD_UNPACK_EN.
package vga_queue_pkg;

    // Output-stage states. UNPACK is only reachable with VGA_WORD_UNPACK_EN.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EMIT   = 2'd1,
        UNPACK = 2'd2
    } vga_state_e;

    // CPU stores at or above this address target the text buffer. The CPU
    // side strips it, so only the low ADDR_WIDTH bits reach the queue.
    localparam logic [31:0] VGA_BASE = 32'h0007_0000;

    localparam logic [7:0] NUL_CHAR = 8'h00;

endpackage

// File: rtl/vga_write_queue_sync_fifo.sv
// Generic synchronous FIFO (module sync_fifo). DEPTH must be a power of 2 so
// the pointers wrap for free. Read data is the current head, shown without
// a pop. Writes to a full FIFO and reads from an empty one are ignored.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 45
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_en,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop_en,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             wr, rd;

    assign full  = (level_q == FULL_LVL);
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rdata = mem[rd_ptr_q];

    assign wr = push_en & ~full;
    assign rd = pop_en & ~empty;

    // Pointer and occupancy next-state; simultaneous push and pop keep level.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({wr, rd})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and level registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/vga_write_queue.sv
// Elastic buffer between the CPU VGA store path and the text-RAM write port.
// Stores are queued in a FIFO and drained as character writes over a
// valid/ready handshake.
// Optional feature macro: VGA_WORD_UNPACK_EN -- expands each stored word into
// up to four characters (bytes 0..3, stopping at the first NUL after byte 0).
//
// state  | meaning
// IDLE   | no character pending; waits for the FIFO to go non-empty
// EMIT   | one character per entry presented; next entry popped on accept
// UNPACK | bytes of the FIFO head presented in turn; head popped after last
module vga_write_queue
    import vga_queue_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_en,
    input  logic [ADDR_WIDTH-1:0]      push_addr,
    input  logic [DATA_WIDTH-1:0]      push_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_WIDTH-1:0]      out_addr,
    output logic [7:0]                 out_char
);

    localparam int EW = ADDR_WIDTH + DATA_WIDTH;

    logic [EW-1:0]         head;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  fifo_empty;
    logic                  pop;

    vga_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
    logic [7:0]            out_char_q, out_char_d;
    logic                  overflow_q;
    logic                  out_valid_c;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_en (push_en),
        .wdata   ({push_addr, push_data}),
        .pop_en  (pop),
        .rdata   (head),
        .full    (full),
        .empty   (fifo_empty),
        .level   (level)
    );

    assign head_addr = head[EW-1:DATA_WIDTH];
    assign head_data = head[DATA_WIDTH-1:0];

`ifdef VGA_WORD_UNPACK_EN
    logic [1:0]            idx_q, idx_d;
    logic [1:0]            next_idx;
    logic [7:0]            next_byte;

    assign next_idx  = idx_q + 2'd1;
    assign next_byte = head_data[{next_idx, 3'b000} +: 8];
`else
    // Upper store bits carry nothing in single-character mode.
    logic unused_hi;
    assign unused_hi = ^head_data[DATA_WIDTH-1:8];
`endif

    // Output-stage next state, FIFO pop and output register loads.
    always_comb begin
        state_d     = state_q;
        out_addr_d  = out_addr_q;
        out_char_d  = out_char_q;
        pop         = 1'b0;
        out_valid_c = 1'b0;
`ifdef VGA_WORD_UNPACK_EN
        idx_d       = idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    out_addr_d = head_addr;
                    out_char_d = head_data[7:0];
`ifdef VGA_WORD_UNPACK_EN
                    // Head stays queued until its last byte is accepted.
                    idx_d      = 2'd0;
                    state_d    = UNPACK;
`else
                    pop        = 1'b1;
                    state_d    = EMIT;
`endif
                end
            end
            EMIT: begin
                out_valid_c = 1'b1;
                if (out_ready) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        out_addr_d = head_addr;
                        out_char_d = head_data[7:0];
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
`ifdef VGA_WORD_UNPACK_EN
            UNPACK: begin
                out_valid_c = 1'b1;
                if (out_ready) begin
                    if (idx_q != 2'd3 && next_byte != NUL_CHAR) begin
                        idx_d      = next_idx;
                        out_addr_d = head_addr + ADDR_WIDTH'(next_idx);
                        out_char_d = next_byte;
                    end else begin
                        pop     = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output-stage registers and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            out_addr_q <= '0;
            out_char_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_addr_q <= out_addr_d;
            out_char_q <= out_char_d;
            overflow_q <= overflow_q | (push_en & full);
        end
    end

`ifdef VGA_WORD_UNPACK_EN
    // Byte index within the word being unpacked.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) idx_q <= 2'd0;
        else      idx_q <= idx_d;
    end
`endif

    assign out_valid = out_valid_c;
    assign out_addr  = out_addr_q;
    assign out_char  = out_char_q;
    assign overflow  = overflow_q;
    assign empty     = fifo_empty && (state_q == IDLE);

endmodule

// File: tb/tb_vga_write_queue.sv
// Directed bench for vga_write_queue. Inputs change 1 time unit after the
// rising edge; outputs are sampled at the same point.
// Note: the output stage takes the first entry out of the FIFO one cycle
// after it is pushed, so with out_ready low it takes nine pushes to fill
// the eight FIFO entries.
module tb_vga_write_queue;

    logic        clk;
    logic        rst;
    logic        push_en;
    logic [12:0] push_addr;
    logic [31:0] push_data;
    logic        full;
    logic        empty;
    logic [3:0]  level;
    logic        overflow;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] out_addr;
    logic [7:0]  out_char;

    int n_cmp;
    int n_err;
    int e;

    vga_write_queue #(
        .DEPTH      (8),
        .ADDR_WIDTH (13),
        .DATA_WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push_en   (push_en),
        .push_addr (push_addr),
        .push_data (push_data),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .overflow  (overflow),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_char  (out_char)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [12:0] a, input logic [31:0] d);
        push_en   = 1'b1;
        push_addr = a;
        push_data = d;
        tick();
        push_en   = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b0;
        push_en   = 1'b0;
        push_addr = '0;
        push_data = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_addr", 32'(out_addr), 32'd0);
        check("rst_char", 32'(out_char), 32'd0);
        rst = 1'b1;
        tick();

`ifdef VGA_WORD_UNPACK_EN
        out_ready = 1'b1;
        push(13'h1FFE, 32'h0043_4241);
        check("u_lat_valid", 32'(out_valid), 32'd0);
        tick();
        check("u0_valid", 32'(out_valid), 32'd1);
        check("u0_char", 32'(out_char), 32'h41);
        check("u0_addr", 32'(out_addr), 32'h1FFE);
        check("u0_empty", 32'(empty), 32'd0);
        tick();
        check("u1_char", 32'(out_char), 32'h42);
        check("u1_addr", 32'(out_addr), 32'h1FFF);
        tick();
        check("u2_char", 32'(out_char), 32'h43);
        check("u2_addr", 32'(out_addr), 32'h0000);
        check("u2_valid", 32'(out_valid), 32'd1);
        tick();
        check("u_stop_valid", 32'(out_valid), 32'd0);
        check("u_stop_empty", 32'(empty), 32'd1);
        push(13'h0010, 32'h0000_0000);
        tick();
        check("uz_valid", 32'(out_valid), 32'd1);
        check("uz_char", 32'(out_char), 32'h00);
        check("uz_addr", 32'(out_addr), 32'h0010);
        tick();
        check("uz_done", 32'(out_valid), 32'd0);
        check("uz_empty", 32'(empty), 32'd1);
`else
        // Single store, latency and return to empty.
        out_ready = 1'b1;
        push(13'h005, 32'h41);
        check("t1_lat_valid", 32'(out_valid), 32'd0);
        check("t1_lat_level", 32'(level), 32'd1);
        tick();
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_addr", 32'(out_addr), 32'h005);
        check("t1_char", 32'(out_char), 32'h41);
        tick();
        check("t1_done", 32'(out_valid), 32'd0);
        check("t1_empty", 32'(empty), 32'd1);

        // Fill to full with out_ready low, overflow, then drain in order.
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) push(13'(12'h100 + i), 32'(8'h30 + i));
        check("t2_full", 32'(full), 32'd1);
        check("t2_level", 32'(level), 32'd8);
        check("t2_ovf0", 32'(overflow), 32'd0);
        check("t2_head", 32'(out_char), 32'h30);
        push(13'h1AA, 32'h39);
        check("t2_ovf1", 32'(overflow), 32'd1);
        check("t2_level_ovf", 32'(level), 32'd8);
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            check("t2_dvalid", 32'(out_valid), 32'd1);
            check("t2_dchar", 32'(out_char), 32'(8'h30 + k));
            check("t2_daddr", 32'(out_addr), 32'(12'h100 + k));
            tick();
        end
        check("t2_end_valid", 32'(out_valid), 32'd0);
        check("t2_end_empty", 32'(empty), 32'd1);
        check("t2_end_ovf", 32'(overflow), 32'd1);

        // Four-entry burst with out_ready toggling 1010...
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(13'(12'h200 + i), 32'(8'h50 + i));
        e = 0;
        for (int c = 0; c < 10; c++) begin
            out_ready = (c % 2 == 0);
            if (e < 4) begin
                check("t3_valid", 32'(out_valid), 32'd1);
                check("t3_char", 32'(out_char), 32'(8'h50 + e));
                check("t3_addr", 32'(out_addr), 32'(12'h200 + e));
                if (out_ready) e++;
            end else begin
                check("t3_idle", 32'(out_valid), 32'd0);
            end
            tick();
        end
        check("t3_count", 32'(e), 32'd4);
        check("t3_empty", 32'(empty), 32'd1);

        // Level 3 with simultaneous push and pop across pointer wraps.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(13'(12'h300 + i), 32'(8'h60 + i));
        check("t4_level3", 32'(level), 32'd3);
        for (int c = 0; c < 6; c++) begin
            push_en   = 1'b1;
            push_addr = 13'(12'h304 + c);
            push_data = 32'(8'h64 + c);
            out_ready = 1'b1;
            check("t4_level", 32'(level), 32'd3);
            check("t4_char", 32'(out_char), 32'(8'h60 + c));
            tick();
        end
        push_en = 1'b0;
        check("t4_level_after", 32'(level), 32'd3);
        for (int c = 6; c < 10; c++) begin
            check("t4_dchar", 32'(out_char), 32'(8'h60 + c));
            check("t4_daddr", 32'(out_addr), 32'(12'h300 + c));
            tick();
        end
        check("t4_done", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-drain.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(13'(12'h400 + i), 32'(8'h70 + i));
        check("t5_pre_level", 32'(level), 32'd5);
        check("t5_pre_valid", 32'(out_valid), 32'd1);
        check("t5_pre_ovf", 32'(overflow), 32'd1);
        rst = 1'b0;
        #1;
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_level", 32'(level), 32'd0);
        check("t5_ovf", 32'(overflow), 32'd0);
        check("t5_empty", 32'(empty), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        out_ready = 1'b1;
        push(13'h007, 32'h5A);
        tick();
        check("t5_post_valid", 32'(out_valid), 32'd1);
        check("t5_post_char", 32'(out_char), 32'h5A);
        check("t5_post_addr", 32'(out_addr), 32'h007);
        tick();
        check("t5_post_empty", 32'(empty), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
